// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave front-end for the synchronous RAM path.
// Deframes MOSI bit-streams into {cmd[1:0], payload} words and returns read data on MISO.
//
// Compile-time option: define SPI_PARITY_EN to add one odd-parity bit to every rx frame
// (after the payload, covering cmd+payload) and to every tx word (after the data bits).
//
// Ports:
//   clk        system clock; SS_n/MOSI are sampled on the rising edge
//   rst_n      synchronous, active-low reset
//   SS_n       slave select, active low
//   MOSI       serial data in
//   tx_data    read data from RAM
//   tx_valid   tx_data valid (only looked at while waiting for read data)
//   MISO       serial data out
//   rx_data    {cmd[1:0], payload} of the last accepted frame
//   rx_valid   one-cycle pulse, rx_data updated
//   tx_ready   slave waiting for tx_data
//   frame_err  one-cycle pulse, frame discarded (abort, cmd mismatch or parity error)
module spi_slave_param #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_ready,
  output logic              frame_err
);

  localparam int unsigned RX_W = DATA_W + 2;
`ifdef SPI_PARITY_EN
  localparam int unsigned RX_LAST = RX_W;        // counter value of the parity bit
  localparam int unsigned SH_W    = RX_W;        // shifter holds cmd+payload, parity is live
  localparam int unsigned TX_LEN  = DATA_W + 1;
`else
  localparam int unsigned RX_LAST = RX_W - 1;
  localparam int unsigned SH_W    = RX_W - 1;    // last bit is taken straight from MOSI
  localparam int unsigned TX_LEN  = DATA_W;
`endif
  localparam int unsigned RXC_W = $clog2(RX_LAST + 1);
  localparam int unsigned TXC_W = $clog2(TX_LEN + 1);

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData,
    StTxWait,
    StTxShift
  } state_e;

  state_e              state_q, state_d;
  logic [RXC_W-1:0]    rx_cnt_q, rx_cnt_d;
  logic [TXC_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic [SH_W-1:0]     rx_sh_q, rx_sh_d;
  logic [TX_LEN-1:0]   tx_sh_q, tx_sh_d;
  logic                addr_read_q, addr_read_d;
  logic                miso_q, miso_d;
  logic [RX_W-1:0]     rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                tx_ready_q, tx_ready_d;
  logic                frame_err_q, frame_err_d;

  // Frame decode helpers.
  logic [RX_W-1:0]   frame_w;   // frame bits in arrival order, first bit at the MSB
  logic [DATA_W-1:0] payload;
  logic [RX_W-1:0]   rx_word;
  logic              par_ok;
  logic              cmd_ok;
  logic              frame_ok;
  logic              rx_last;
  logic [TX_LEN-1:0] tx_seq;    // bit i is the i-th bit to put on MISO
  logic              tx_done;

  always_comb begin
`ifdef SPI_PARITY_EN
    frame_w = rx_sh_q;
    par_ok  = ^{rx_sh_q, MOSI};
`else
    frame_w = {rx_sh_q, MOSI};
    par_ok  = 1'b1;
`endif
    for (int i = 0; i < DATA_W; i++) begin
      payload[i] = MSB_FIRST ? frame_w[i] : frame_w[DATA_W-1-i];
    end
    rx_word = {frame_w[RX_W-1:RX_W-2], payload};

    case (state_q)
      StReadAdd:  cmd_ok = (frame_w[RX_W-1:RX_W-2] == 2'b10);
      StReadData: cmd_ok = (frame_w[RX_W-1:RX_W-2] == 2'b11);
      default:    cmd_ok = 1'b1;
    endcase
    frame_ok = cmd_ok & par_ok;
    rx_last  = (rx_cnt_q == RXC_W'(RX_LAST));

    for (int i = 0; i < DATA_W; i++) begin
      tx_seq[i] = MSB_FIRST ? tx_data[DATA_W-1-i] : tx_data[i];
    end
`ifdef SPI_PARITY_EN
    tx_seq[DATA_W] = ~^tx_data;
`endif
    tx_done = (tx_cnt_q == TXC_W'(TX_LEN));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!SS_n) state_d = StChkCmd;
      end
      StChkCmd: begin
        if (SS_n)             state_d = StIdle;
        else if (!MOSI)       state_d = StWrite;
        else if (addr_read_q) state_d = StReadData;
        else                  state_d = StReadAdd;
      end
      StWrite, StReadAdd, StReadData: begin
        if (SS_n) begin
          state_d = StIdle;
        end else if (rx_last) begin
          state_d = (state_q == StReadData && frame_ok) ? StTxWait : StChkCmd;
        end
      end
      StTxWait: begin
        if (SS_n)          state_d = StIdle;
        else if (tx_valid) state_d = StTxShift;
      end
      StTxShift: begin
        // Completion takes priority: all bits are already out, so SS_n only picks the target.
        if (tx_done)   state_d = SS_n ? StIdle : StChkCmd;
        else if (SS_n) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath next-state logic.
  always_comb begin
    rx_cnt_d    = rx_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    addr_read_d = addr_read_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_ready_d  = tx_ready_q;
    frame_err_d = 1'b0;

    case (state_q)
      StIdle: begin
        rx_cnt_d   = '0;
        tx_cnt_d   = '0;
        miso_d     = 1'b0;
        tx_ready_d = 1'b0;
      end
      StChkCmd: begin
        if (SS_n) begin
          rx_cnt_d = '0;
        end else begin
          rx_sh_d  = {rx_sh_q[SH_W-2:0], MOSI};
          rx_cnt_d = RXC_W'(1);
        end
      end
      StWrite, StReadAdd, StReadData: begin
        if (SS_n) begin
          rx_cnt_d    = '0;
          miso_d      = 1'b0;
          tx_ready_d  = 1'b0;
          frame_err_d = 1'b1;
        end else if (rx_last) begin
          rx_cnt_d = '0;
          if (frame_ok) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            if (state_q == StReadAdd)  addr_read_d = 1'b1;
            if (state_q == StReadData) tx_ready_d  = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_sh_d  = {rx_sh_q[SH_W-2:0], MOSI};
          rx_cnt_d = rx_cnt_q + RXC_W'(1);
        end
      end
      StTxWait: begin
        miso_d = 1'b0;
        if (SS_n) begin
          tx_ready_d  = 1'b0;
          frame_err_d = 1'b1;
        end else if (tx_valid) begin
          miso_d     = tx_seq[0];
          tx_sh_d    = tx_seq >> 1;
          tx_cnt_d   = TXC_W'(1);
          tx_ready_d = 1'b0;
        end
      end
      StTxShift: begin
        if (tx_done) begin
          miso_d      = 1'b0;
          addr_read_d = 1'b0;
          tx_cnt_d    = '0;
        end else if (SS_n) begin
          miso_d      = 1'b0;
          addr_read_d = 1'b0;
          tx_cnt_d    = '0;
          tx_ready_d  = 1'b0;
          frame_err_d = 1'b1;
        end else begin
          miso_d   = tx_sh_q[0];
          tx_sh_d  = tx_sh_q >> 1;
          tx_cnt_d = tx_cnt_q + TXC_W'(1);
        end
      end
      default: begin
        rx_cnt_d = '0;
        tx_cnt_d = '0;
        miso_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      addr_read_q <= 1'b0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_cnt_q    <= rx_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      addr_read_q <= addr_read_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_ready_q  <= tx_ready_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_ready  = tx_ready_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised SPI slave front-end for the synchronous RAM path. It deframes MOSI bit-streams into command+payload words and returns read data on MISO.
- Generalises the fixed 10-bit/8-bit slave:
  - configurable payload width and bit order
  - command-consistency checking
  - frame-abort detection
  - explicit tx handshake
- Sits between the SPI pins (already synchronous to clk) and the RAM controller.

Parameters:
- DATA_W, 8: payload and read-data width. rx word width RX_W = DATA_W+2.
- MSB_FIRST, 1: 1 = rx and tx shift MSB-first; 0 = LSB-first.

Ports:
- clk  in  1  system clock; SS_n/MOSI sampled on rising edge
- rst_n  in  1  synchronous, active-low reset
- SS_n  in  1  slave select, active low
- MOSI  in  1  serial data in
- tx_data  in  DATA_W  read data from RAM
- tx_valid  in  1  tx_data valid
- MISO  out  1  serial data out
- rx_data  out  DATA_W+2  {cmd[1:0], payload}
- rx_valid  out  1  one-cycle pulse, rx_data complete
- tx_ready  out  1  slave waiting for tx_data
- frame_err  out  1  one-cycle pulse, frame discarded

Behaviour:
- Reset (rst_n=0 at a clk edge) clears:
  - outputs: MISO, rx_data, rx_valid, tx_ready, frame_err all 0
  - internal: state=IDLE, counters 0, addr_read=0
- Reset mid-frame or mid-tx aborts the operation immediately. No frame_err is raised for a reset abort.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT.
- IDLE -> CHK_CMD on the first edge with SS_n=0.
- CHK_CMD samples frame bit 0 (cmd[1]) into the rx shifter, then:
  - cmd[1]=0 -> WRITE
  - cmd[1]=1 and addr_read=0 -> READ_ADD
  - cmd[1]=1 and addr_read=1 -> READ_DATA
- WRITE / READ_ADD / READ_DATA shift the remaining RX_W-1 bits. rx counter runs 1..RX_W-1.
- On the edge sampling the last bit (counter=RX_W-1):
  - rx_data is updated
  - rx_valid=1 for exactly one cycle
  - counter clears
- Frame order: cmd[1], cmd[0], then payload. Payload order follows MSB_FIRST; cmd bits are always first.
- Command check at frame end:
  - READ_ADD requires cmd=10; READ_DATA requires cmd=11.
  - On mismatch: rx_valid stays 0, frame_err pulses, rx_data keeps its previous value, addr_read is unchanged.
- Completion transitions:
  - WRITE: after rx_valid, the next frame starts in CHK_CMD if SS_n is still low (back-to-back frames allowed).
  - READ_ADD: on a valid frame, addr_read<=1, then CHK_CMD.
  - READ_DATA: on a valid frame -> TX_WAIT with tx_ready=1.
- TX_WAIT:
  - MISO=0 while waiting.
  - The first edge with tx_valid=1 loads the shifter and drives MISO = first bit (tx_data[DATA_W-1] if MSB_FIRST).
  - tx_ready drops on that same edge; state -> TX_SHIFT.
- TX_SHIFT:
  - Each edge drives the next bit, DATA_W bits total.
  - On the edge after the last bit: MISO<=0, addr_read<=0, state -> CHK_CMD if SS_n is low, else IDLE.
- tx_valid is ignored outside TX_WAIT.
- Abort: SS_n=1 at any edge outside IDLE with a partial frame or tx in progress:
  - state -> IDLE, counters clear, MISO<=0, tx_ready<=0
  - frame_err pulses one cycle
  - addr_read is unchanged, except an abort during TX_SHIFT clears it
- SS_n=1 in CHK_CMD (no bits yet) -> IDLE with no frame_err.
- rx_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro: SPI_PARITY_EN.
- Defined:
  - Each rx frame carries one extra odd-parity bit after the payload, covering cmd+payload. The rx counter extends to RX_W.
  - rx_valid is raised only if parity is correct; parity failure pulses frame_err and has the same effect as a command mismatch.
  - tx appends one odd-parity bit after the DATA_W data bits, making the tx phase DATA_W+1 cycles.
- Undefined: no parity bits; frame lengths exactly as above.

Test Plan:
- Write frame, DATA_W=8:
  - Stimulus: SS_n low, MOSI bits 0,0,1,0,1,0,0,1,0,1.
  - Response: rx_valid high one cycle on the 10th sampling edge, rx_data=10'h0A5, frame_err=0.
- Read-address then read-data:
  - Frame 1: bits 10_00000011 -> rx_data=10'h203; addr_read set.
  - Frame 2: bits 11_00000000 -> rx_data=10'h300, tx_ready=1.
  - tx_valid with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 on 8 consecutive edges, then 0; tx_ready cleared.
- Command mismatch:
  - Stimulus: with addr_read=0, send 11_01010101.
  - Response: frame routed via READ_ADD, cmd check fails, frame_err pulse, rx_valid stays 0, rx_data unchanged.
- Abort:
  - Stimulus: SS_n raised after 5 frame bits.
  - Response: frame_err pulse one cycle, no rx_valid, state IDLE. A following full write frame 00_11111111 yields rx_data=10'h0FF.
- MSB_FIRST=0, DATA_W=16:
  - Stimulus: send 00 then payload 16'h1234 LSB-first.
  - Response: rx_data=18'h01234; read path shifts tx_data=16'hA5F0 out LSB-first.
- Reset mid-TX_SHIFT:
  - Stimulus: rst_n=0 after 3 tx bits.
  - Response: next edge MISO=0, tx_ready=0, addr_read=0, no frame_err. With SPI_PARITY_EN, a bad-parity write frame gives frame_err only.
